arm_data_mem: RTL and testbench

//   Data-side responder for the pipelined ARM core: serves the memory-stage load/store port.

---
 rtl/arm_data_mem.sv | 116 +++++++++++
 tb/tb_arm_data_mem.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/arm_data_mem.sv
// arm_data_mem: word RAM plus an MMIO TX byte FIFO on the ARM core data port.
// Define CYCLE_COUNTER_EN to map a free-running CYCLES register at 0xFFFF_FF08.
module arm_data_mem #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [29:0] TXDATA_W = 30'h3FFF_FFC0;
  localparam logic [29:0] STATUS_W = 30'h3FFF_FFC1;
  localparam logic [PW:0] PTR_ONE  = 1;

  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  fifo [FIFO_DEPTH];
  logic [AW-1:0] word;
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic is_ram;
  logic is_tx;
  logic is_status;
  logic empty;
  logic full;
  logic pop;
  logic tx_wr;
  logic push;
  logic ovf;
  logic unused;

  assign word      = ALUResult[AW+1:2];
  assign is_ram    = !ALUResult[31];
  assign is_tx     = ALUResult[31:2] == TXDATA_W;
  assign is_status = ALUResult[31:2] == STATUS_W;
  assign unused    = &{1'b0, ALUResult[1:0]};

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign io_tx_valid = !empty;
  assign io_tx_data  = fifo[rd_ptr[PW-1:0]];
  assign pop   = io_tx_valid && io_tx_ready;
  assign tx_wr = MemWrite && is_tx;
  assign push  = tx_wr && (!full || pop);

`ifdef CYCLE_COUNTER_EN
  localparam logic [29:0] CYCLES_W = 30'h3FFF_FFC2;
  logic        is_cycles;
  logic [31:0] cycles;

  assign is_cycles = ALUResult[31:2] == CYCLES_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles <= '0;
    end else if (MemWrite && is_cycles) begin
      cycles <= WriteData;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (MemWrite && is_ram) begin
      ram[word] <= WriteData;
    end
  end

  // Push into a full FIFO with a pop reuses the slot being drained this edge.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr[PW-1:0]] <= WriteData[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (tx_wr && full && !pop) begin
        ovf <= 1'b1;
      end else if (MemWrite && is_status && WriteData[2]) begin
        ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    ReadData = '0;
    unique case (1'b1)
      is_ram:    ReadData = ram[word];
      is_status: ReadData = {29'b0, ovf, full, empty};
`ifdef CYCLE_COUNTER_EN
      is_cycles: ReadData = cycles;
`endif
      default:   ReadData = '0;
    endcase
  end
endmodule

// File: tb/tb_arm_data_mem.sv
// tb_arm_data_mem: random and directed stimulus against a queue-based model;
// TX bytes are checked by a scoreboard monitor decoupled from the driver.
module tb_arm_data_mem;
  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] TXA = 32'hFFFF_FF00;
  localparam logic [31:0] STA = 32'hFFFF_FF04;
  localparam logic [31:0] CYA = 32'hFFFF_FF08;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mq[$];
  logic [7:0]  exp_q[$];
  logic [31:0] ram_m [int];
  logic        ovf_m;
  logic [31:0] cyc_m;

  always #5 clk = ~clk;

  arm_data_mem #(
    .RAM_WORDS(RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .io_tx_data(io_tx_data),
    .io_tx_valid(io_tx_valid),
    .io_tx_ready(io_tx_ready)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_read(input logic [31:0] a,
                                    output logic [31:0] v);
    int idx;
    v = '0;
    if (!a[31]) begin
      idx = int'((a >> 2) % RAM_WORDS);
      if (!ram_m.exists(idx)) return 1'b0;
      v = ram_m[idx];
    end else if (a[31:2] == STA[31:2]) begin
      v = {29'b0, ovf_m, mq.size() == FIFO_DEPTH, mq.size() == 0};
`ifdef CYCLE_COUNTER_EN
    end else if (a[31:2] == CYA[31:2]) begin
      v = cyc_m;
`endif
    end
    return 1'b1;
  endfunction

  task automatic step(input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    logic [31:0] v;
    bit known;
    bit pop;
    MemWrite    = we;
    ALUResult   = a;
    WriteData   = d;
    io_tx_ready = rdy;
    @(negedge clk);
    #1;
    known = model_read(a, v);
    if (known) check("read_data", ReadData, v);
    check("tx_valid", 32'(io_tx_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("tx_head", 32'(io_tx_data), 32'(mq[0]));
    pop = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (we && (a[31:2] == CYA[31:2])) cyc_m = d;
    else cyc_m = cyc_m + 32'd1;
    if (we) begin
      if (!a[31]) begin
        ram_m[int'((a >> 2) % RAM_WORDS)] = d;
      end else if (a[31:2] == TXA[31:2]) begin
        if (mq.size() < FIFO_DEPTH) begin
          mq.push_back(d[7:0]);
          exp_q.push_back(d[7:0]);
        end else begin
          ovf_m = 1'b1;
        end
      end else if (a[31:2] == STA[31:2] && d[2]) begin
        ovf_m = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    MemWrite    = 1'b0;
    ALUResult   = STA;
    io_tx_ready = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_valid", 32'(io_tx_valid), 32'd0);
    mq.delete();
    exp_q.delete();
    ovf_m = 1'b0;
    cyc_m = '0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && io_tx_valid && io_tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %h, expected no byte", io_tx_data);
      end else begin
        check("tx_byte", 32'(io_tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int op;
    logic rdy;
    logic [31:0] r;
    reset = 1'b0;
    MemWrite = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    io_tx_ready = 1'b0;
    ovf_m = 1'b0;
    cyc_m = '0;
    #1 reset = 1'b1;
    #1 check("reset_valid", 32'(io_tx_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    step(0, STA, 0, 0);
    step(1, 32'h10, 32'hDEAD_BEEF, 0);
    step(0, 32'h10, 0, 0);
    step(0, 32'h10 + 4 * RAM_WORDS, 0, 0);

    step(1, TXA, 32'h41, 0);
    step(1, TXA, 32'h42, 0);
    step(0, STA, 0, 0);
    step(0, STA, 0, 0);
    repeat (3) step(0, STA, 0, 1);

    for (int i = 0; i < 9; i++) step(1, TXA, 32'h60 + i, 0);
    step(0, STA, 0, 0);
    repeat (10) step(0, STA, 0, 1);
    step(1, STA, 32'h4, 0);
    step(0, STA, 0, 0);

    for (int i = 0; i < FIFO_DEPTH; i++) step(1, TXA, 32'h70 + i, 0);
    step(1, TXA, 32'h55, 1);
    step(0, STA, 0, 0);
    repeat (FIFO_DEPTH + 1) step(0, STA, 0, 1);

    for (int i = 0; i < 3; i++) step(1, TXA, 32'h80 + i, 0);
    mid_reset();
    step(0, STA, 0, 0);

    step(1, CYA, 32'hFFFF_FFFE, 0);
    repeat (3) step(0, CYA, 0, 0);

    for (int n = 0; n < 600; n++) begin
      op = int'($urandom_range(0, 9));
      if (((n / 50) % 2) == 1) rdy = ($urandom_range(0, 3) == 0);
      else rdy = ($urandom_range(0, 3) != 0);
      r = $urandom;
      unique case (op)
        0, 1, 2: step(1, {1'b0, r[30:0]}, $urandom, rdy);
        3, 4:    step(0, {1'b0, r[30:0]}, 0, rdy);
        5, 6:    step(1, TXA, $urandom, rdy);
        7:       step(0, STA, 0, rdy);
        8:       step(1, STA, $urandom, rdy);
        default: begin
          unique case (r[1:0])
            2'd0: step(r[2], 32'hFFFF_FF0C, $urandom, rdy);
            2'd1: step(r[2], 32'h8000_0000 | (r & 32'h0FFF_FFFC),
                       $urandom, rdy);
            2'd2: step(r[2], CYA, $urandom, rdy);
            default: step(0, TXA, 0, rdy);
          endcase
        end
      endcase
    end
    repeat (FIFO_DEPTH + 2) step(0, STA, 0, 1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
